// File: rtl/fp_norm_round_pipe.sv
// fp_norm_round_pipe: two-stage normalise-and-round pipeline for raw FP mantissa products.
// Define FP_NORM_ROUND_EN for round-to-nearest-even; the default build truncates.
module fp_norm_round_pipe #(
  parameter int MWIDTH = 23,
  parameter int EWIDTH = 8,
  parameter int M      = 2*(MWIDTH+1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [M-1:0]      in_mant,
  input  logic [EWIDTH+1:0] in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MWIDTH-1:0] out_mant,
  output logic [EWIDTH-1:0] out_exp,
  output logic [2:0]        out_flags
);
  localparam int EXW = EWIDTH + 2;
  localparam int LZW = $clog2(M);
`ifdef FP_NORM_ROUND_EN
  // Rounding needs the whole shifted product for guard and sticky.
  localparam int SW   = M;
  localparam int GIDX = SW - 2 - MWIDTH;
  localparam logic [SW-1:0] STICKY_MASK = (SW'(1) << GIDX) - SW'(1);
`else
  localparam int SW   = MWIDTH + 1;
`endif
  localparam logic signed [EXW-1:0] EXP_MAX = EXW'((1 << EWIDTH) - 1);

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic              s1_adv;
  logic [SW-1:0]     s1_mant_q, s1_mant_d;
  logic [EXW-1:0]    s1_exp_q, s1_exp_d;
  logic [MWIDTH-1:0] out_mant_q, out_mant_d;
  logic [EWIDTH-1:0] out_exp_q, out_exp_d;
  logic [2:0]        out_flags_q, out_flags_d;
  logic [LZW-1:0]    lz;
  logic [M-1:0]      shifted;
  logic [MWIDTH-1:0] frac;
  logic              carry;
  logic signed [EXW-1:0] e_adj;

  // Scanning upward lets the highest set bit win the last assignment.
  always_comb begin
    lz = '0;
    for (int i = 0; i < M; i++) begin
      if (in_mant[i]) lz = LZW'(M - 1 - i);
    end
  end

  assign shifted = in_mant << lz;

  always_comb begin
    s1_adv     = !s2_valid_q || out_ready;
    in_ready   = !s1_valid_q || s1_adv;
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s2_valid_d = s1_adv ? s1_valid_q : s2_valid_q;
  end

  // NOTE: every always_comb output is defaulted first, so no path can infer a latch.
  always_comb begin
    s1_mant_d = s1_mant_q;
    s1_exp_d  = s1_exp_q;
    if (in_valid && in_ready) begin
      s1_mant_d = shifted[M-1 -: SW];
      s1_exp_d  = in_exp - EXW'(lz) + EXW'(1);
    end
  end

  // After normalisation the hidden bit is clear only for a zero product.
  always_comb begin
    frac  = s1_mant_q[SW-2 -: MWIDTH];
    carry = 1'b0;
`ifdef FP_NORM_ROUND_EN
    if (s1_mant_q[GIDX] && ((|(s1_mant_q & STICKY_MASK)) || frac[0]))
      {carry, frac} = {1'b0, frac} + (MWIDTH+1)'(1);
`endif
    e_adj = s1_exp_q + EXW'(carry);

    out_mant_d  = out_mant_q;
    out_exp_d   = out_exp_q;
    out_flags_d = out_flags_q;
    if (s1_adv && s1_valid_q) begin
      if (!s1_mant_q[SW-1]) begin
        out_mant_d  = '0;
        out_exp_d   = '0;
        out_flags_d = 3'b001;
      end else if (e_adj >= EXP_MAX) begin
        out_mant_d  = '0;
        out_exp_d   = '1;
        out_flags_d = 3'b100;
      end else if (e_adj[EXW-1] || (e_adj == '0)) begin
        out_mant_d  = '0;
        out_exp_d   = '0;
        out_flags_d = 3'b010;
      end else begin
        out_mant_d  = frac;
        out_exp_d   = e_adj[EWIDTH-1:0];
        out_flags_d = 3'b000;
      end
    end
  end

  // NOTE: S1 payload is qualified by s1_valid_q, so it is left without reset.
  always_ff @(posedge clk) begin
    s1_mant_q <= s1_mant_d;
    s1_exp_q  <= s1_exp_d;
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_mant_q  <= '0;
      out_exp_q   <= '0;
      out_flags_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_mant_q  <= out_mant_d;
      out_exp_q   <= out_exp_d;
      out_flags_q <= out_flags_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_mant  = out_mant_q;
  assign out_exp   = out_exp_q;
  assign out_flags = out_flags_q;

endmodule

// File: tb/tb_fp_norm_round_pipe.sv
// Bench for fp_norm_round_pipe: directed corners, stall scenario, randomized stream with
// backpressure against an arithmetic reference model, and reset with beats in flight.
`timescale 1ns/1ps
module tb_fp_norm_round_pipe;
  localparam int MWIDTH = 23;
  localparam int EWIDTH = 8;
  localparam int M      = 2*(MWIDTH+1);
  localparam int EXW    = EWIDTH + 2;
`ifdef FP_NORM_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  typedef struct packed {
    logic [MWIDTH-1:0] mant;
    logic [EWIDTH-1:0] ex;
    logic [2:0]        flags;
  } res_t;

  typedef struct packed {
    logic [M-1:0]   mant;
    logic [EXW-1:0] ein;
    res_t           want;
  } vec_t;

  typedef struct packed {
    res_t        want;
    logic [31:0] cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [M-1:0]      in_mant;
  logic [EXW-1:0]    in_exp;
  logic              out_valid;
  logic              out_ready;
  logic [MWIDTH-1:0] out_mant;
  logic [EWIDTH-1:0] out_exp;
  logic [2:0]        out_flags;

  int n_cmp = 0;
  int n_bad = 0;

  fp_norm_round_pipe #(.MWIDTH(MWIDTH), .EWIDTH(EWIDTH), .M(M)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mant(in_mant), .in_exp(in_exp),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mant(out_mant), .out_exp(out_exp), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  function automatic int wrap(input int x);
    int w;
    w = x & ((1 << EXW) - 1);
    if (w >= (1 << (EXW - 1))) w -= (1 << EXW);
    return w;
  endfunction

  // Reference: value-level normalise, round by comparing the remainder with one half.
  function automatic res_t model(input logic [M-1:0] mant, input logic [EXW-1:0] ein);
    res_t r;
    longint unsigned m64, norm, frac, rem, half;
    int lz, e, s;
    bit carry;
    r = '0;
    if (mant == '0) begin
      r.flags = 3'b001;
      return r;
    end
    m64   = 64'(mant);
    lz    = M - $clog2(m64 + 64'd1);
    norm  = m64 << lz;
    s     = M - 1 - MWIDTH;
    frac  = (norm >> s) & ((64'd1 << MWIDTH) - 64'd1);
    rem   = norm & ((64'd1 << s) - 64'd1);
    half  = 64'd1 << (s - 1);
    carry = 1'b0;
    if (RND && (rem > half || (rem == half && frac[0]))) begin
      frac++;
      if (frac == (64'd1 << MWIDTH)) begin
        frac  = 0;
        carry = 1'b1;
      end
    end
    e = wrap(wrap(int'($signed(ein)) - lz + 1) + int'(carry));
    if (e >= (1 << EWIDTH) - 1) begin
      r.ex    = '1;
      r.flags = 3'b100;
    end else if (e <= 0) begin
      r.flags = 3'b010;
    end else begin
      r.mant = frac[MWIDTH-1:0];
      r.ex   = e[EWIDTH-1:0];
    end
    return r;
  endfunction

  function automatic logic [M-1:0] rand_mant();
    logic [63:0]  r;
    logic [M-1:0] m;
    r = {$urandom(), $urandom()};
    m = r[M-1:0];
    case ($urandom_range(0, 9))
      0:       m = '0;
      1, 2, 3: m = m >> $urandom_range(1, M - 1);
      4: begin
        m[M-1] = 1'b1;
        m[M-2-MWIDTH:0] = '0;
        m[M-2-MWIDTH]   = 1'b1;
      end
      5:       m[M-1 -: MWIDTH+2] = '1;
      default: m[M-1] = 1'b1;
    endcase
    return m;
  endfunction

  function automatic logic [EXW-1:0] rand_exp();
    if ($urandom_range(0, 4) != 0) return EXW'(int'($urandom_range(0, 320)) - 30);
    return EXW'($urandom());
  endfunction

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_mant   = '0;
    in_exp    = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if ({out_mant, out_exp, out_flags} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got mant=%h exp=%h flags=%b want all 0", out_mant, out_exp, out_flags);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    vec_t dir[11];
    exp_t q[$];
    exp_t x;
    res_t got;
    int   sent = 0, rcv = 0, cyc = 0;
    dir[0]  = {48'h8000_0000_0000, 10'd127, 23'h0, 8'd128, 3'b000};
    dir[1]  = {48'h4000_0000_0000, 10'd127, 23'h0, 8'd127, 3'b000};
    dir[2]  = RND ? {48'hFFFF_FF80_0000, 10'd127, 23'h0, 8'd129, 3'b000}
                  : {48'hFFFF_FF80_0000, 10'd127, 23'h7FFFFF, 8'd128, 3'b000};
    dir[3]  = {48'h8000_0080_0000, 10'd127, 23'h0, 8'd128, 3'b000};
    dir[4]  = {48'h8000_0000_0000, 10'd254, 23'h0, 8'd255, 3'b100};
    dir[5]  = {48'h4000_0000_0000, 10'd0,   23'h0, 8'd0,   3'b010};
    dir[6]  = {48'h0,              10'd77,  23'h0, 8'd0,   3'b001};
    dir[7]  = {48'h0000_0000_0001, 10'd200, 23'h0, 8'd154, 3'b000};
    dir[8]  = {48'h8000_0000_0000, 10'h3FF, 23'h0, 8'd0,   3'b010};
    dir[9]  = RND ? {48'hFFFF_FF80_0000, 10'd253, 23'h0, 8'd255, 3'b100}
                  : {48'hFFFF_FF80_0000, 10'd253, 23'h7FFFFF, 8'd254, 3'b000};
    dir[10] = {48'h0,              10'd254, 23'h0, 8'd0,   3'b001};
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    while (rcv < 11 && cyc < 100) begin
      in_valid = (sent < 11);
      if (sent < 11) begin
        in_mant = dir[sent].mant;
        in_exp  = dir[sent].ein;
      end
      @(negedge clk);
      if (in_valid) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_bad++;
          $display("FAIL directed_in_ready: got %b want 1 at beat %0d", in_ready, sent);
        end
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL directed_spurious: got out_valid=1 want 0 (no beat pending)");
        end else begin
          x   = q.pop_front();
          got = {out_mant, out_exp, out_flags};
          n_cmp++;
          if (got !== x.want) begin
            n_bad++;
            $display("FAIL directed_%0d: got mant=%h exp=%h flags=%b want mant=%h exp=%h flags=%b",
                     rcv, out_mant, out_exp, out_flags, x.want.mant, x.want.ex, x.want.flags);
          end
          n_cmp++;
          if (cyc - int'(x.cyc) != 2) begin
            n_bad++;
            $display("FAIL directed_latency_%0d: got %0d cycles want 2", rcv, cyc - int'(x.cyc));
          end
          rcv++;
        end
      end
      if (in_valid && in_ready) begin
        q.push_back({dir[sent].want, 32'(cyc)});
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (rcv != 11) begin
      n_bad++;
      $display("FAIL directed_timeout: got %0d beats want 11", rcv);
    end
  endtask

  task automatic test_backpressure();
    res_t q[$];
    res_t got, want, hold_val;
    bit   hold = 1'b0;
    bit [2:0] ready_want = 3'b011;
    int   sent = 0, rcv = 0, cyc = 0;
    @(posedge clk);
    #1;
    while (rcv < 4 && cyc < 50) begin
      in_valid = (sent < 4);
      in_mant  = M'(48'h8000_0000_0000) | (M'(sent + 1) << 30);
      in_exp   = EXW'(120 + sent);
      out_ready = (cyc >= 3);
      @(negedge clk);
      got = {out_mant, out_exp, out_flags};
      if (cyc < 3) begin
        n_cmp++;
        if (in_ready !== ready_want[cyc]) begin
          n_bad++;
          $display("FAIL bp_in_ready_c%0d: got %b want %b", cyc, in_ready, ready_want[cyc]);
        end
      end
      if (hold) begin
        n_cmp++;
        if (out_valid !== 1'b1 || got !== hold_val) begin
          n_bad++;
          $display("FAIL bp_stall_stable: got valid=%b data=%h want valid=1 data=%h", out_valid, got, hold_val);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL bp_spurious: got out_valid=1 want 0 (no beat pending)");
        end else begin
          want = q.pop_front();
          if (got !== want) begin
            n_bad++;
            $display("FAIL bp_order_%0d: got %h want %h", rcv, got, want);
          end
          rcv++;
        end
      end
      hold     = out_valid && !out_ready;
      hold_val = got;
      if (in_valid && in_ready) begin
        q.push_back(model(in_mant, in_exp));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (rcv != 4) begin
      n_bad++;
      $display("FAIL bp_timeout: got %0d beats want 4", rcv);
    end
  endtask

  task automatic test_random();
    res_t q[$];
    res_t got, want, hold_val;
    bit   hold = 1'b0, stuck = 1'b0;
    int   n = 400, sent = 0, rcv = 0, cyc = 0;
    @(posedge clk);
    #1;
    while (rcv < n && cyc < 20000) begin
      if (!stuck) begin
        if (sent < n && $urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_mant  = rand_mant();
          in_exp   = rand_exp();
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 9) < 6);
      @(negedge clk);
      got = {out_mant, out_exp, out_flags};
      if (hold) begin
        n_cmp++;
        if (out_valid !== 1'b1 || got !== hold_val) begin
          n_bad++;
          $display("FAIL rand_stall_stable: got valid=%b data=%h want valid=1 data=%h", out_valid, got, hold_val);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL rand_spurious: got out_valid=1 want 0 (no beat pending)");
        end else begin
          want = q.pop_front();
          if (got !== want) begin
            n_bad++;
            $display("FAIL rand_beat_%0d: got mant=%h exp=%h flags=%b want mant=%h exp=%h flags=%b",
                     rcv, out_mant, out_exp, out_flags, want.mant, want.ex, want.flags);
          end
          rcv++;
        end
      end
      hold     = out_valid && !out_ready;
      hold_val = got;
      stuck    = in_valid && !in_ready;
      if (in_valid && in_ready) begin
        q.push_back(model(in_mant, in_exp));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (rcv != n) begin
      n_bad++;
      $display("FAIL rand_timeout: got %0d beats want %0d", rcv, n);
    end
  endtask

  task automatic test_reset_midflight();
    res_t want;
    int   seen = 0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mant   = 48'h8000_0000_0000;
    in_exp    = 10'd127;
    @(posedge clk);
    #1 in_mant = 48'h4000_0000_0000;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_loaded: got out_valid=%b want 1", out_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_out_valid: got %b want 0", out_valid);
    end
    n_cmp++;
    if ({out_mant, out_exp, out_flags} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got mant=%h exp=%h flags=%b want all 0", out_mant, out_exp, out_flags);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_in_ready: got %b want 1", in_ready);
    end
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++;
      $display("FAIL rst_mid_stale: got %0d stale beats want 0", seen);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_mant  = 48'h0000_0001_2345;
    in_exp   = 10'd60;
    want     = model(in_mant, in_exp);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_early: got out_valid=%b want 0 one cycle after accept", out_valid);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || {out_mant, out_exp, out_flags} !== want) begin
      n_bad++;
      $display("FAIL rst_mid_new_beat: got valid=%b data=%h want valid=1 data=%h",
               out_valid, {out_mant, out_exp, out_flags}, want);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_norm_round_pipe.md
FP_NORM_ROUND_PIPE -- requirements
Module: fp_norm_round_pipe

Interface
REQ-001 SHALL have parameter MWIDTH, default 23, stored fraction width.
REQ-002 SHALL have parameter EWIDTH, default 8, biased exponent width.
REQ-003 SHALL have parameter M, default 2*(MWIDTH+1), raw product width; legal range MWIDTH+2 to 2*(MWIDTH+1).
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, the input beat is valid.
REQ-007 SHALL have port in_ready, output, 1, the block accepts a beat this cycle.
REQ-008 SHALL have port in_mant, input, M, unsigned raw mantissa product.
REQ-009 SHALL have port in_exp, input, EWIDTH+2, two's-complement pre-normalisation exponent.
REQ-010 SHALL have port out_valid, output, 1, the output beat is valid.
REQ-011 SHALL have port out_ready, input, 1, the consumer accepts the beat.
REQ-012 SHALL have port out_mant, output, MWIDTH, normalised fraction with hidden bit removed.
REQ-013 SHALL have port out_exp, output, EWIDTH, normalised biased exponent.
REQ-014 SHALL have port out_flags, output, 3, {ovf, unf, zero}.

Function
REQ-015 SHALL be a 2-stage pipeline: S1 = leading-zero count plus left shift; S2 = rounding, exponent adjust, flags; latency exactly 2 cycles with no stall.
REQ-016 SHALL complete a handshake when valid and ready are both high on a rising edge; in_ready = !s1_valid || s1_adv, s1_adv = !s2_valid || out_ready, out_valid = s2_valid.
REQ-017 SHALL hold out_mant, out_exp and out_flags stable while out_valid && !out_ready, with no drop, duplication or reordering of beats.
REQ-018 SHALL accept one beat per cycle at full throughput when out_ready is held high.
REQ-019 S1 SHALL compute lz = number of leading zeros of in_mant (0..M-1) and shift in_mant left by lz, so the hidden bit lands at bit M-1.
REQ-020 S2 SHALL take the fraction from bits M-2 down to M-1-MWIDTH, the guard bit from the next bit down, and sticky as the OR of all remaining lower bits.
REQ-021 SHALL compute the exponent in EWIDTH+2-bit signed arithmetic as e = in_exp - lz + 1.
REQ-022 If rounding carries out of the fraction, SHALL set the fraction to 0 and increment e by 1 before the range checks.
REQ-023 If e >= 2^EWIDTH-1, SHALL output exp all-ones and fraction 0, and set ovf.
REQ-024 If e <= 0, SHALL output exp 0 and fraction 0 (flush-to-zero), and set unf.
REQ-025 If in_mant == 0, SHALL output exp 0 and fraction 0, set zero only, and ignore in_exp.
REQ-026 At most one flag SHALL be set per beat; zero has priority over ovf, and ovf over unf.

Reset
REQ-027 On rst_n low, SHALL clear s1_valid and s2_valid immediately, and clear out_mant, out_exp and out_flags to 0.
REQ-028 SHALL discard any beat in flight when reset asserts mid-operation, and SHALL produce no out_valid until a new beat is accepted after reset deasserts.
REQ-029 in_ready SHALL read 1 in the first cycle after reset deasserts.

Configuration
REQ-030 With macro FP_NORM_ROUND_EN defined, S2 SHALL round to nearest, ties to even: increment when guard && (sticky || fraction lsb).
REQ-031 Without FP_NORM_ROUND_EN, S2 SHALL truncate (no increment, no carry path); guard and sticky logic may be removed, and all other behaviour is unchanged.

Verification
REQ-032 Stall-free beat, in_mant=48'h8000_0000_0000, in_exp=127 -> after 2 cycles out_mant=0, out_exp=128, flags=0; with in_mant=48'h4000_0000_0000 -> out_exp=127.
REQ-033 Rounding case, in_mant=48'hFFFF_FF80_0000, in_exp=127 -> with FP_NORM_ROUND_EN out_mant=0, out_exp=129; without it out_mant=23'h7FFFFF, out_exp=128.
REQ-034 Tie case, in_mant=48'h8000_0080_0000, in_exp=127 (tie, lsb 0) -> out_mant=0, out_exp=128 in both builds.
REQ-035 Range cases -> in_exp=254 with bit 47 set gives out_exp=255, ovf; in_exp=0 with bit 46 set gives out_exp=0, unf; in_mant=0 gives zero flag.
REQ-036 Backpressure: stream 4 beats with out_ready low for 3 cycles -> in_ready falls after 2 beats are held, all 4 beats emerge in order, and outputs stay stable while stalled.
REQ-037 Reset with 2 beats in flight -> out_valid=0 at once; after release, in_ready=1 and no stale beat appears.
